rv32i_fetch_unit: RTL and testbench

RV32I_FETCH_UNIT -- requirements
Module: rv32i_fetch_unit

---
 rtl/rv32i_pkg.sv | 14 +
 rtl/rv32i_fetch_fifo.sv | 59 +++++
 rtl/rv32i_fetch_unit.sv | 95 +++++++++
 tb/tb_rv32i_fetch_unit.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types and constants.
// Holds XLEN, the canonical NOP encoding and the fetch-buffer entry type.
package rv32i_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/rv32i_fetch_fifo.sv
// In-order instruction buffer of {pc,instr} entries.
// Ports: clk, reset (async, active-high), push/push_data, pop, flush,
// head (oldest entry), count, empty, full.
module rv32i_fetch_fifo
    import rv32i_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [CW-1:0] count,
    output logic         empty,
    output logic         full
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: entries are only visible while count > 0.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch with credit-limited memory requests.
// Ports: clk, reset, imem_* request/response, redirect/redirect_pc,
// if_valid/if_ready/if_pc/if_instr toward IF/ID.
module rv32i_fetch_unit
    import rv32i_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    localparam int          CW         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   live_cnt;
    logic [CW-1:0]   kill_cnt;
    logic [CW-1:0]   fifo_count;
    logic [CW:0]     credit_used;
    logic            grant;
    logic            keep_rsp;
    logic            fifo_pop;
    logic            fifo_empty;
    logic            fifo_full_unused;
    fetch_entry_t    rsp_entry;
    fetch_entry_t    head;

    assign credit_used = {1'b0, fifo_count} + {1'b0, live_cnt}
                       + {1'b0, kill_cnt};

    // Gated by reset so the request drops the moment reset asserts.
    assign imem_req  = !reset && (credit_used < CREDIT_MAX);
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;

    assign keep_rsp = imem_rvalid && (kill_cnt == '0) && !redirect;
    assign fifo_pop = if_valid && if_ready && !redirect;

    // Live requests are consecutive words ending just below fetch_pc,
    // so the oldest one sits live_cnt words back.
    assign rsp_entry = '{
        pc:    fetch_pc - (XLEN'(live_cnt) << 2),
        instr: imem_rdata
    };

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            live_cnt <= '0;
            kill_cnt <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & ~32'h3;
            live_cnt <= '0;
            kill_cnt <= kill_cnt + live_cnt + CW'(grant)
                      - CW'(imem_rvalid);
        end else begin
            if (grant) fetch_pc <= fetch_pc + 32'd4;
            if (imem_rvalid && kill_cnt != '0) kill_cnt <= kill_cnt - CW'(1);
            live_cnt <= live_cnt + CW'(grant) - CW'(keep_rsp);
        end
    end

    rv32i_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (keep_rsp),
        .push_data (rsp_entry),
        .pop       (fifo_pop),
        .flush     (redirect),
        .head      (head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full_unused)
    );

    assign if_valid = !fifo_empty;
    assign if_pc    = fifo_empty ? '0 : head.pc;
    assign if_instr = fifo_empty ? NOP_INSTR : head.instr;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed and randomized bench for rv32i_fetch_unit.
// Models memory and the expected in-order instruction stream.
module tb_rv32i_fetch_unit;
    import rv32i_pkg::*;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h00000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    rv32i_fetch_unit #(
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (RST_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_ready    (if_ready),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          pops     = 0;
    int          gnt_pct  = 100;
    int          lat_lo   = 1;
    int          lat_hi   = 1;
    int          n;
    logic [31:0] exp_fetch;
    logic [31:0] exp_pc;
    logic [31:0] mq_addr [$];
    int          mq_due  [$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return 32'h00500093 + (a << 5);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then check outputs.
    task automatic step(input logic rdy, input logic redir,
                        input logic [31:0] rpc);
        logic g;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = instr_of(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        g           = ($urandom_range(99) < gnt_pct);
        imem_gnt    = g;
        if_ready    = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        if (imem_req && g) begin
            chk("grant_addr", imem_addr, exp_fetch);
            mq_addr.push_back(imem_addr);
            mq_due.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
            exp_fetch += 32'd4;
        end
        if (if_valid && rdy && !redir) begin
            exp_pc += 32'd4;
            pops++;
        end
        if (redir) begin
            exp_fetch = rpc & ~32'h3;
            exp_pc    = exp_fetch;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (if_valid) begin
            chk("if_pc", if_pc, exp_pc);
            chk("if_instr", if_instr, instr_of(exp_pc));
        end else begin
            chk("idle_pc", if_pc, 32'h0);
            chk("idle_instr", if_instr, NOP_INSTR);
        end
        chk("outstanding_le_depth", 32'(mq_addr.size() <= DEPTH), 32'h1);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        if_ready    = 1'b0;
        mq_addr.delete();
        mq_due.delete();
        repeat (2) @(posedge clk);
        #3;
        reset     = 1'b0;
        exp_fetch = RST_PC;
        exp_pc    = RST_PC;
        #1;
        chk("rel_req", imem_req, 32'h1);
        chk("rel_addr", imem_addr, RST_PC);
        chk("rel_valid", if_valid, 32'h0);
    endtask

    task automatic wait_valid(input string tag);
        n = 0;
        while (!if_valid && n < 30) begin
            step(1'b1, 1'b0, '0);
            n++;
        end
        chk(tag, if_valid, 32'h1);
    endtask

    initial begin
        reset       = 1'b1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        if_ready    = 1'b0;
        #1;
        chk("rst_req", imem_req, 32'h0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_valid", if_valid, 32'h0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, NOP_INSTR);

        // First fetch latency and streaming rate.
        do_reset();
        gnt_pct = 100; lat_lo = 1; lat_hi = 1;
        step(1'b1, 1'b0, '0);
        chk("first_valid_early", if_valid, 32'h0);
        chk("first_next_addr", imem_addr, 32'h4);
        step(1'b1, 1'b0, '0);
        chk("first_valid", if_valid, 32'h1);
        chk("first_pc", if_pc, 32'h0);
        chk("first_instr", if_instr, 32'h00500093);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, '0);
            chk("stream_valid", if_valid, 32'h1);
        end

        // Stall fills the buffer, then drains without a gap.
        do_reset();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);
        chk("stall_req", imem_req, 32'h0);
        chk("stall_valid", if_valid, 32'h1);
        gnt_pct = 0;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", if_valid, 32'h1);
            chk("drain_pc", if_pc, 32'(4 * i));
            step(1'b1, 1'b0, '0);
        end
        chk("drain_empty", if_valid, 32'h0);

        // Redirect with two requests outstanding.
        do_reset();
        gnt_pct = 100; lat_lo = 4; lat_hi = 4;
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b0, '0);
        gnt_pct = 0;
        step(1'b1, 1'b1, 32'h00000103);
        chk("rdr_addr", imem_addr, 32'h00000100);
        gnt_pct = 100; lat_lo = 1; lat_hi = 1;
        wait_valid("rdr_valid");
        chk("rdr_pc", if_pc, 32'h00000100);

        // Redirect colliding with grant and response.
        do_reset();
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'h00000200);
        wait_valid("coll_valid");
        chk("coll_pc", if_pc, 32'h00000200);
        step(1'b1, 1'b1, 32'h00000300);
        step(1'b1, 1'b1, 32'h00000400);
        wait_valid("multi_valid");
        chk("multi_pc", if_pc, 32'h00000400);

        // Address wrap at the top of memory.
        gnt_pct = 0;
        step(1'b1, 1'b1, 32'hFFFFFFFC);
        gnt_pct = 100;
        step(1'b1, 1'b0, '0);
        chk("wrap_addr", imem_addr, 32'h0);
        wait_valid("wrap_valid");
        chk("wrap_pc_hi", if_pc, 32'hFFFFFFFC);
        step(1'b1, 1'b0, '0);
        chk("wrap_pc_lo", if_pc, 32'h0);

        // Reset in the middle of a burst.
        do_reset();
        lat_lo = 6; lat_hi = 6;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_req", imem_req, 32'h0);
        chk("mid_rst_addr", imem_addr, RST_PC);
        chk("mid_rst_valid", if_valid, 32'h0);
        chk("mid_rst_pc", if_pc, 32'h0);
        chk("mid_rst_instr", if_instr, NOP_INSTR);
        do_reset();
        gnt_pct = 0;
        step(1'b1, 1'b0, '0);
        chk("post_rst_empty", if_valid, 32'h0);

        // Randomized traffic.
        gnt_pct = 70; lat_lo = 1; lat_hi = 5;
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(3) != 0, $urandom_range(19) == 0,
                 $urandom);
        end

        // Everything outstanding must settle and streaming resume.
        gnt_pct = 100; lat_lo = 1; lat_hi = 1;
        pops = 0;
        for (int i = 0; i < 30; i++) step(1'b1, 1'b0, '0);
        chk("drain_progress", 32'(pops > 15), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
